// File: rtl/array_allocator.sv
// array_allocator
//
// Hands out heap array numbers for the interpreter, keeps a LIFO stack of
// freed arrays, and tracks how many arrays are live (in_use) and the
// high-water mark of that count (allocs). Every newly allocated array has
// its NArea heap words zeroed through the dedicated heap write port before
// alloc_ack is raised.
//
// Ports:
//   clock, reset_n         single clock, asynchronous active-low reset
//   alloc_req              pulse: request an array (ignored while busy)
//   free_req, free_array   pulse: release free_array (ignored while busy)
//   busy                   a request is being processed
//   alloc_ack, alloc_array one-cycle pulse; alloc_array held until the next ack
//   free_ack               one-cycle pulse: free completed
//   error                  one-cycle pulse: exhausted, out of range or double free
//   heap_we, heap_addr,    heap zeroing port, address = array*NArea + offset,
//   heap_wdata             data is always 0
//   in_use, allocs         live array count and its maximum since reset

module array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 20,
  parameter int NArea              = 4,
  parameter int NFreedArrays       = 20
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             alloc_req,
  input  logic                             free_req,
  input  logic [MemoryElementWidth-1:0]    free_array,
  output logic                             busy,
  output logic                             alloc_ack,
  output logic [MemoryElementWidth-1:0]    alloc_array,
  output logic                             free_ack,
  output logic                             error,
  output logic                             heap_we,
  output logic [MemoryElementWidth-1:0]    heap_addr,
  output logic [MemoryElementWidth-1:0]    heap_wdata,
  output logic [$clog2(NArrays+1)-1:0]     in_use,
  output logic [$clog2(NArrays+1)-1:0]     allocs
);

  localparam int MW   = MemoryElementWidth;
  localparam int CW   = $clog2(NArrays + 1);
  localparam int IDXW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int SPW  = $clog2(NFreedArrays + 1);
  localparam int OFW  = (NArea > 1) ? $clog2(NArea) : 1;

  localparam logic [MW-1:0]  N_ARRAYS_MW = MW'(NArrays);
  localparam logic [CW-1:0]  N_ARRAYS_CW = CW'(NArrays);
  localparam logic [OFW-1:0] LAST_OFS    = OFW'(NArea - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  // What DONE should report on its single cycle.
  typedef enum logic [1:0] {
    PEND_ALLOC = 2'd0,
    PEND_FREE  = 2'd1,
    PEND_ERR   = 2'd2
  } pend_t;

  state_t             state_q, state_d;
  pend_t              pend_q, pend_d;
  logic [OFW-1:0]     offset_q, offset_d;
  logic [MW-1:0]      alloc_array_q, alloc_array_d;
  logic [CW-1:0]      next_fresh_q, next_fresh_d;
  logic [SPW-1:0]     sp_q, sp_d;
  logic [MW-1:0]      stack_q [NFreedArrays];
  logic [MW-1:0]      stack_d [NFreedArrays];
  logic [NArrays-1:0] bits_q, bits_d;
  logic [CW-1:0]      in_use_q, in_use_d;
  logic [CW-1:0]      allocs_q, allocs_d;

  logic [IDXW-1:0]    free_idx;
  logic [IDXW-1:0]    new_idx;
  logic               free_ok;
  logic               got_array;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pend_q        <= PEND_ALLOC;
      offset_q      <= '0;
      alloc_array_q <= '0;
      next_fresh_q  <= '0;
      sp_q          <= '0;
      for (int i = 0; i < NFreedArrays; i++) begin
        stack_q[i] <= '0;
      end
      bits_q        <= '0;
      in_use_q      <= '0;
      allocs_q      <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      offset_q      <= offset_d;
      alloc_array_q <= alloc_array_d;
      next_fresh_q  <= next_fresh_d;
      sp_q          <= sp_d;
      for (int i = 0; i < NFreedArrays; i++) begin
        stack_q[i] <= stack_d[i];
      end
      bits_q        <= bits_d;
      in_use_q      <= in_use_d;
      allocs_q      <= allocs_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    offset_d      = offset_q;
    alloc_array_d = alloc_array_q;
    next_fresh_d  = next_fresh_q;
    sp_d          = sp_q;
    for (int i = 0; i < NFreedArrays; i++) begin
      stack_d[i] = stack_q[i];
    end
    bits_d        = bits_q;
    in_use_d      = in_use_q;
    allocs_d      = allocs_q;

    new_idx       = '0;
    got_array     = 1'b0;
    free_idx      = free_array[IDXW-1:0];
    // The range check must come first so the bitmap index is meaningful.
    free_ok       = (free_array < N_ARRAYS_MW) && bits_q[free_idx];

    busy          = (state_q != IDLE);
    alloc_ack     = 1'b0;
    free_ack      = 1'b0;
    error         = 1'b0;
    heap_we       = 1'b0;
    heap_addr     = '0;
    heap_wdata    = '0;

    case (state_q)
      IDLE: begin
        // A free has priority; a simultaneous alloc is dropped.
        if (free_req) begin
          if (free_ok) begin
            stack_d[sp_q]    = free_array;
            sp_d             = sp_q + SPW'(1);
            bits_d[free_idx] = 1'b0;
            in_use_d         = in_use_q - CW'(1);
            pend_d           = PEND_FREE;
          end else begin
            pend_d           = PEND_ERR;
          end
          state_d = DONE;
        end else if (alloc_req) begin
          // Reuse the most recently freed array before touching fresh ones.
          if (sp_q != '0) begin
            alloc_array_d = stack_q[sp_q - SPW'(1)];
            sp_d          = sp_q - SPW'(1);
            got_array     = 1'b1;
          end else if (next_fresh_q < N_ARRAYS_CW) begin
            alloc_array_d = MW'(next_fresh_q);
            next_fresh_d  = next_fresh_q + CW'(1);
            got_array     = 1'b1;
          end

          if (got_array) begin
            new_idx         = alloc_array_d[IDXW-1:0];
            bits_d[new_idx] = 1'b1;
            in_use_d        = in_use_q + CW'(1);
            if (in_use_d > allocs_q) begin
              allocs_d = in_use_d;
            end
            offset_d = '0;
            state_d  = CLEAR;
          end else begin
            pend_d  = PEND_ERR;
            state_d = DONE;
          end
        end
      end

      CLEAR: begin
        heap_we   = 1'b1;
        heap_addr = alloc_array_q * MW'(NArea) + MW'(offset_q);
        if (offset_q == LAST_OFS) begin
          pend_d  = PEND_ALLOC;
          state_d = DONE;
        end else begin
          offset_d = offset_q + OFW'(1);
        end
      end

      DONE: begin
        case (pend_q)
          PEND_ALLOC: alloc_ack = 1'b1;
          PEND_FREE:  free_ack  = 1'b1;
          default:    error     = 1'b1;
        endcase
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign alloc_array = alloc_array_q;
  assign in_use      = in_use_q;
  assign allocs      = allocs_q;

endmodule

// File: tb/tb_array_allocator.sv
// tb_array_allocator
//
// Directed bench for array_allocator with the default parameters
// (12-bit words, 20 arrays, 4 heap words per array). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.

module tb_array_allocator;

  logic        clock;
  logic        reset_n;
  logic        alloc_req;
  logic        free_req;
  logic [11:0] free_array;
  logic        busy;
  logic        alloc_ack;
  logic [11:0] alloc_array;
  logic        free_ack;
  logic        error;
  logic        heap_we;
  logic [11:0] heap_addr;
  logic [11:0] heap_wdata;
  logic [4:0]  in_use;
  logic [4:0]  allocs;

  int checks   = 0;
  int failures = 0;

  array_allocator #(
    .MemoryElementWidth(12),
    .NArrays(20),
    .NArea(4),
    .NFreedArrays(20)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .alloc_req(alloc_req),
    .free_req(free_req),
    .free_array(free_array),
    .busy(busy),
    .alloc_ack(alloc_ack),
    .alloc_array(alloc_array),
    .free_ack(free_ack),
    .error(error),
    .heap_we(heap_we),
    .heap_addr(heap_addr),
    .heap_wdata(heap_wdata),
    .in_use(in_use),
    .allocs(allocs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present a request for exactly one rising edge; returns mid-way through
  // the cycle after the edge that sampled it.
  task automatic applyStimulus(input logic a, input logic f, input logic [11:0] arr);
    @(negedge clock);
    alloc_req  = a;
    free_req   = f;
    free_array = arr;
    @(negedge clock);
    alloc_req  = 1'b0;
    free_req   = 1'b0;
    free_array = '0;
  endtask

  task automatic doAlloc(input int expArr, input int expInUse, input int expAllocs);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("alloc_busy_rise", 32'(busy), 1);
    checkOutput("alloc_in_use", 32'(in_use), expInUse);
    checkOutput("alloc_allocs", 32'(allocs), expAllocs);
    checkOutput("heap_wdata", 32'(heap_wdata), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("heap_we", 32'(heap_we), 1);
      checkOutput("heap_addr", 32'(heap_addr), expArr * 4 + i);
      checkOutput("early_alloc_ack", 32'(alloc_ack), 0);
      @(negedge clock);
    end
    checkOutput("alloc_ack", 32'(alloc_ack), 1);
    checkOutput("alloc_array", 32'(alloc_array), expArr);
    checkOutput("done_heap_we", 32'(heap_we), 0);
    checkOutput("done_busy", 32'(busy), 1);
    @(negedge clock);
    checkOutput("alloc_ack_drop", 32'(alloc_ack), 0);
    checkOutput("alloc_busy_fall", 32'(busy), 0);
    checkOutput("alloc_array_held", 32'(alloc_array), expArr);
  endtask

  task automatic doFree(input int arr, input bit expOk, input int expInUse);
    applyStimulus(1'b0, 1'b1, 12'(arr));
    checkOutput("free_ack", 32'(free_ack), 32'(expOk));
    checkOutput("free_error", 32'(error), 32'(!expOk));
    checkOutput("free_busy", 32'(busy), 1);
    checkOutput("free_heap_we", 32'(heap_we), 0);
    checkOutput("free_in_use", 32'(in_use), expInUse);
    @(negedge clock);
    checkOutput("free_busy_fall", 32'(busy), 0);
    checkOutput("free_ack_drop", 32'(free_ack), 0);
    checkOutput("free_error_drop", 32'(error), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_alloc_ack"}, 32'(alloc_ack), 0);
    checkOutput({tag, "_free_ack"}, 32'(free_ack), 0);
    checkOutput({tag, "_error"}, 32'(error), 0);
    checkOutput({tag, "_heap_we"}, 32'(heap_we), 0);
    checkOutput({tag, "_alloc_array"}, 32'(alloc_array), 0);
    checkOutput({tag, "_heap_addr"}, 32'(heap_addr), 0);
    checkOutput({tag, "_heap_wdata"}, 32'(heap_wdata), 0);
    checkOutput({tag, "_in_use"}, 32'(in_use), 0);
    checkOutput({tag, "_allocs"}, 32'(allocs), 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    alloc_req  = 1'b0;
    free_req   = 1'b0;
    free_array = '0;
    #12;
    checkAllZero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Fresh allocations come out in order.
    doAlloc(0, 1, 1);
    doAlloc(1, 2, 2);
    doAlloc(2, 3, 3);
    checkOutput("in_use_3", 32'(in_use), 3);
    checkOutput("allocs_3", 32'(allocs), 3);

    // LIFO reuse of freed arrays, then back to fresh ones.
    doFree(1, 1'b1, 2);
    doFree(0, 1'b1, 1);
    doAlloc(0, 2, 3);
    doAlloc(1, 3, 3);
    doAlloc(3, 4, 4);
    checkOutput("allocs_4", 32'(allocs), 4);

    // Bad frees: never allocated, out of range, double free.
    doFree(5, 1'b0, 4);
    doFree(25, 1'b0, 4);
    doFree(2, 1'b1, 3);
    doFree(2, 1'b0, 3);
    checkOutput("allocs_after_frees", 32'(allocs), 4);
    // Stack holds only array 2; the failed frees pushed nothing.
    doAlloc(2, 4, 4);

    // Fill the remaining fresh arrays, then exhaust.
    for (int a = 4; a < 20; a++) begin
      doAlloc(a, a + 1, a + 1);
    end
    checkOutput("in_use_full", 32'(in_use), 20);
    checkOutput("allocs_full", 32'(allocs), 20);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("exhaust_error", 32'(error), 1);
    checkOutput("exhaust_heap_we", 32'(heap_we), 0);
    checkOutput("exhaust_alloc_ack", 32'(alloc_ack), 0);
    checkOutput("exhaust_in_use", 32'(in_use), 20);
    @(negedge clock);
    checkOutput("exhaust_error_drop", 32'(error), 0);
    checkOutput("exhaust_busy_fall", 32'(busy), 0);

    // Simultaneous free and alloc: only the free is served.
    applyStimulus(1'b1, 1'b1, 12'd0);
    checkOutput("simul_free_ack", 32'(free_ack), 1);
    checkOutput("simul_alloc_ack", 32'(alloc_ack), 0);
    checkOutput("simul_heap_we", 32'(heap_we), 0);
    checkOutput("simul_error", 32'(error), 0);
    checkOutput("simul_in_use", 32'(in_use), 19);
    @(negedge clock);
    checkOutput("simul_busy_fall", 32'(busy), 0);
    doAlloc(0, 20, 20);

    // Reset in the middle of clearing an array.
    doFree(7, 1'b1, 19);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("pre_reset_addr0", 32'(heap_addr), 28);
    @(negedge clock);
    checkOutput("pre_reset_addr1", 32'(heap_addr), 29);
    reset_n = 1'b0;
    #1;
    checkAllZero("midclear_reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("post_reset_no_ack", 32'(alloc_ack), 0);
    doAlloc(0, 1, 1);
    checkOutput("post_reset_allocs", 32'(allocs), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
